// File: rtl/line_burst_adaptor_if.sv
// Bus bundle between the cache, the line/burst adaptor and memory.
// slave is the adaptor's view; master is the cache+memory side.
interface line_burst_adaptor_if;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/line_burst_adaptor.sv
// Converts 256-bit cache line transfers into 4x64-bit memory bursts.
// All memory-side and cache-side outputs are registered.
module line_burst_adaptor #(
    parameter int BEATS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    line_burst_adaptor_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [1:0] LAST = 2'(BEATS - 1);

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [31:0]  addr_q, addr_d;
    logic [255:0] wline_q, wline_d;
    logic [255:0] rline_q, rline_d;
    logic         read_q, read_d;
    logic         write_q, write_d;
    logic         resp_q, resp_d;
    logic [63:0]  burst_q, burst_d;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        unique case (state_q)
            IDLE: begin
                if (bus.write_i) begin
                    state_d = WRITE;
                    addr_d  = bus.address_i;
                    wline_d = bus.line_i;
                    cnt_d   = 2'd0;
                end else if (bus.read_i) begin
                    state_d = READ;
                    addr_d  = bus.address_i;
                    cnt_d   = 2'd0;
                end
            end
            READ: begin
                if (bus.resp_i) begin
                    rline_d[{cnt_q, 6'd0} +: 64] = bus.burst_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == LAST) state_d = DONE;
                end
            end
            WRITE: begin
                if (bus.resp_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == LAST) state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        read_d  = (state_d == READ);
        write_d = (state_d == WRITE);
        resp_d  = (state_d == DONE);
        burst_d = (state_d == WRITE) ? wline_d[{cnt_d, 6'd0} +: 64]
                                     : 64'd0;
    end

    // State register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= 32'd0;
            wline_q <= 256'd0;
            rline_q <= 256'd0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
            burst_q <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
            read_q  <= read_d;
            write_q <= write_d;
            resp_q  <= resp_d;
            burst_q <= burst_d;
        end
    end

    assign bus.line_o    = rline_q;
    assign bus.resp_o    = resp_q;
    assign bus.burst_o   = burst_q;
    assign bus.address_o = addr_q;
    assign bus.read_o    = read_q;
    assign bus.write_o   = write_q;
endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed self-checking bench for line_burst_adaptor.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_line_burst_adaptor;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    int   pulses = 0;
    int   accepted = 0;

    line_burst_adaptor_if bus();

    line_burst_adaptor #(.BEATS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    task automatic chk(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        if (bus.write_o && bus.resp_i) accepted++;
        @(posedge clk);
        #1;
        if (bus.resp_o) pulses++;
    endtask

    task automatic beat(input logic [63:0] d);
        bus.resp_i  = 1'b1;
        bus.burst_i = d;
        step();
    endtask

    logic [255:0] rl1, rl2, rl3, wl, wl2;

    initial begin
        rl1 = {rep(8'h44), rep(8'h33), rep(8'h22), rep(8'h11)};
        rl2 = {rep(8'h88), rep(8'h77), rep(8'h66), rep(8'h55)};
        rl3 = {rep(8'hDD), rep(8'hCC), rep(8'hBB), rep(8'h99)};
        wl  = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
               64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};
        wl2 = {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002,
               64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000};

        rst = 1'b1;
        bus.line_i = '0;
        bus.address_i = '0;
        bus.read_i = 1'b0;
        bus.write_i = 1'b0;
        bus.burst_i = '0;
        bus.resp_i = 1'b0;
        step();
        step();
        chk("rst_read_o", 256'(bus.read_o), 256'd0);
        chk("rst_write_o", 256'(bus.write_o), 256'd0);
        chk("rst_resp_o", 256'(bus.resp_o), 256'd0);
        chk("rst_addr_o", 256'(bus.address_o), 256'd0);
        chk("rst_burst_o", 256'(bus.burst_o), 256'd0);
        chk("rst_line_o", bus.line_o, 256'd0);
        rst = 1'b0;
        step();

        // basic read, contiguous beats
        pulses = 0;
        bus.read_i = 1'b1;
        bus.address_i = 32'h0000_1240;
        step();
        bus.read_i = 1'b0;
        chk("rd_read_o", 256'(bus.read_o), 256'd1);
        chk("rd_write_o", 256'(bus.write_o), 256'd0);
        chk("rd_addr_o", 256'(bus.address_o), 256'h1240);
        beat(rep(8'h11));
        chk("rd_beat0", 256'(bus.line_o[63:0]), 256'(rep(8'h11)));
        beat(rep(8'h22));
        beat(rep(8'h33));
        chk("rd_no_early_resp", 256'(bus.resp_o), 256'd0);
        beat(rep(8'h44));
        chk("rd_resp_cycle6", 256'(bus.resp_o), 256'd1);
        chk("rd_read_drop", 256'(bus.read_o), 256'd0);
        chk("rd_line", bus.line_o, rl1);
        bus.resp_i = 1'b1;
        bus.burst_i = rep(8'hEE);
        step();
        chk("rd_resp_one", 256'(bus.resp_o), 256'd0);
        chk("rd_idle_resp_ign", bus.line_o, rl1);
        bus.resp_i = 1'b0;
        step();
        chk("rd_pulses", 256'(pulses), 256'd1);

        // write with gapped acceptance 1,0,1,1,0,1
        pulses = 0;
        accepted = 0;
        bus.write_i = 1'b1;
        bus.line_i = wl;
        bus.address_i = 32'h0000_8000;
        step();
        bus.write_i = 1'b0;
        chk("wr_write_o", 256'(bus.write_o), 256'd1);
        chk("wr_addr_o", 256'(bus.address_o), 256'h8000);
        chk("wr_b0", 256'(bus.burst_o), 256'(wl[63:0]));
        bus.resp_i = 1'b1; step();
        chk("wr_b1", 256'(bus.burst_o), 256'(wl[127:64]));
        bus.resp_i = 1'b0; step();
        chk("wr_b1_gap", 256'(bus.burst_o), 256'(wl[127:64]));
        bus.resp_i = 1'b1; step();
        chk("wr_b2", 256'(bus.burst_o), 256'(wl[191:128]));
        bus.resp_i = 1'b1; step();
        chk("wr_b3", 256'(bus.burst_o), 256'(wl[255:192]));
        bus.resp_i = 1'b0; step();
        chk("wr_b3_gap", 256'(bus.burst_o), 256'(wl[255:192]));
        chk("wr_still_busy", 256'(bus.write_o), 256'd1);
        bus.resp_i = 1'b1; step();
        bus.resp_i = 1'b0;
        chk("wr_write_drop", 256'(bus.write_o), 256'd0);
        chk("wr_resp", 256'(bus.resp_o), 256'd1);
        chk("wr_burst_zero", 256'(bus.burst_o), 256'd0);
        chk("wr_line_o_kept", bus.line_o, rl1);
        step();
        chk("wr_pulses", 256'(pulses), 256'd1);
        chk("wr_accepted", 256'(accepted), 256'd4);

        // read+write together, then stray read_i and resp_i
        pulses = 0;
        accepted = 0;
        bus.read_i = 1'b1;
        bus.write_i = 1'b1;
        bus.line_i = wl2;
        bus.address_i = 32'h0000_2000;
        step();
        bus.write_i = 1'b0;
        chk("rw_write_o", 256'(bus.write_o), 256'd1);
        chk("rw_read_o", 256'(bus.read_o), 256'd0);
        chk("rw_line_o", bus.line_o, rl1);
        bus.address_i = 32'h0000_3300;
        beat(rep(8'hF0));
        beat(rep(8'hF1));
        chk("rw_b2", 256'(bus.burst_o), 256'(wl2[191:128]));
        chk("rw_addr_hold", 256'(bus.address_o), 256'h2000);
        beat(rep(8'hF2));
        beat(rep(8'hF3));
        bus.read_i = 1'b0;
        chk("rw_resp", 256'(bus.resp_o), 256'd1);
        step();
        step();
        bus.resp_i = 1'b0;
        chk("rw_idle_read_o", 256'(bus.read_o), 256'd0);
        chk("rw_idle_write_o", 256'(bus.write_o), 256'd0);
        chk("rw_pulses", 256'(pulses), 256'd1);
        chk("rw_accepted", 256'(accepted), 256'd4);
        chk("rw_line_o_kept", bus.line_o, rl1);

        // reset after two read beats, then a fresh read
        pulses = 0;
        bus.read_i = 1'b1;
        bus.address_i = 32'h0000_3000;
        step();
        bus.read_i = 1'b0;
        beat(rep(8'hAA));
        beat(rep(8'hBB));
        bus.resp_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_read_o", 256'(bus.read_o), 256'd0);
        chk("mr_line_o", bus.line_o, 256'd0);
        chk("mr_resp_o", 256'(bus.resp_o), 256'd0);
        bus.resp_i = 1'b1;
        bus.burst_i = rep(8'h12);
        step();
        chk("mr_idle_ign", bus.line_o, 256'd0);
        chk("mr_no_pulse", 256'(pulses), 256'd0);
        bus.read_i = 1'b1;
        bus.resp_i = 1'b0;
        bus.address_i = 32'h0000_4000;
        step();
        bus.read_i = 1'b0;
        chk("mr2_addr_o", 256'(bus.address_o), 256'h4000);
        beat(rep(8'h55));
        beat(rep(8'h66));
        beat(rep(8'h77));
        beat(rep(8'h88));
        bus.resp_i = 1'b0;
        chk("mr2_resp", 256'(bus.resp_o), 256'd1);
        chk("mr2_line", bus.line_o, rl2);
        step();

        // back-to-back read: old line held until beat 0
        bus.read_i = 1'b1;
        bus.address_i = 32'h0000_5000;
        step();
        bus.read_i = 1'b0;
        chk("bb_hold_accept", bus.line_o, rl2);
        bus.resp_i = 1'b0;
        step();
        chk("bb_hold_gap", bus.line_o, rl2);
        beat(rep(8'h99));
        chk("bb_beat0", bus.line_o, {rl2[255:64], rep(8'h99)});
        beat(rep(8'hBB));
        bus.resp_i = 1'b0;
        step();
        chk("bb_gap_hold", bus.line_o,
            {rl2[255:128], rep(8'hBB), rep(8'h99)});
        beat(rep(8'hCC));
        beat(rep(8'hDD));
        bus.resp_i = 1'b0;
        chk("bb_resp", 256'(bus.resp_o), 256'd1);
        chk("bb_line", bus.line_o, rl3);
        step();
        chk("bb_line_idle", bus.line_o, rl3);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/line_burst_adaptor.md
LINE_BURST_ADAPTOR -- requirements
Module: line_burst_adaptor

Interface
REQ-001 SHALL have parameter BEATS, default 4, meaning the number of 64-bit beats per 256-bit line; only the value 4 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port line_i, input, 256 bits: line from the cache for a write-back.
REQ-005 SHALL have port line_o, output, 256 bits: line assembled from a read burst.
REQ-006 SHALL have port address_i, input, 32 bits: line address from the cache; bits [4:0] are zero.
REQ-007 SHALL have port read_i, input, 1 bit: cache line-fill request.
REQ-008 SHALL have port write_i, input, 1 bit: cache write-back request.
REQ-009 SHALL have port resp_o, output, 1 bit: one-cycle completion pulse to the cache.
REQ-010 SHALL have port burst_i, input, 64 bits: read beat from memory.
REQ-011 SHALL have port burst_o, output, 64 bits: write beat to memory.
REQ-012 SHALL have port address_o, output, 32 bits: latched line address to memory.
REQ-013 SHALL have port read_o, output, 1 bit: memory burst-read request.
REQ-014 SHALL have port write_o, output, 1 bit: memory burst-write request.
REQ-015 SHALL have port resp_i, input, 1 bit: memory beat-valid / beat-accepted strobe.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WRITE, DONE and a 2-bit beat counter.
REQ-017 SHALL sample read_i/write_i only in IDLE; requests in any other state are ignored.
REQ-018 SHALL, in IDLE with write_i=1, latch address_i and line_i, clear the counter, and go to WRITE; write_i takes priority when read_i=1 in the same cycle.
REQ-019 SHALL, in IDLE with read_i=1 and write_i=0, latch address_i, clear the counter, and go to READ.
REQ-020 SHALL drive address_o from the latched address in READ and WRITE, and hold its last value otherwise.
REQ-021 SHALL assert read_o exactly while in READ, and write_o exactly while in WRITE (registered; first asserted the cycle after acceptance).
REQ-022 SHALL, in READ, on each cycle with resp_i=1, store burst_i into line_o[64*cnt+63 : 64*cnt] (beat 0 = bits [63:0]) and increment cnt.
REQ-023 SHALL, in WRITE, drive burst_o = latched line[64*cnt+63 : 64*cnt]; each cycle with resp_i=1 accepts that beat and increments cnt.
REQ-024 SHALL tolerate non-contiguous beats: a cycle with resp_i=0 holds cnt and data unchanged.
REQ-025 SHALL, on the cycle resp_i=1 with cnt=3 (wraps to 0), go to DONE; read_o/write_o drop the next cycle.
REQ-026 SHALL assert resp_o for exactly the one cycle spent in DONE, then return to IDLE.
REQ-027 SHALL have a best-case latency, request to resp_o, of 6 cycles (1 accept + 4 contiguous beats + 1 DONE).
REQ-028 SHALL hold line_o stable from DONE until the next read burst writes beat 0; a write burst never modifies line_o.
REQ-029 SHALL ignore resp_i in IDLE and DONE.
REQ-030 SHALL rely on the cache deasserting read_i/write_i in the resp_o cycle; a request still high in the IDLE cycle after DONE starts a new transaction.
REQ-031 SHALL drive burst_o = 0 outside WRITE.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, enter IDLE with cnt=0, read_o=0, write_o=0, resp_o=0, address_o=0, burst_o=0, line_o=0, and latched line=0.
REQ-033 SHALL, on reset mid-burst, abandon the transaction with no resp_o pulse, discard the partial line, and deassert read_o/write_o the next cycle.
REQ-034 SHALL give rst priority over all other inputs.

Verification
REQ-035 SHALL pass this scenario: read_i with address_i=0x0000_1240; resp_i high for 4 cycles with burst_i=0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x0000_1240, line_o={0x44..44,0x33..33,0x22..22,0x11..11}, resp_o one pulse at cycle 6.
REQ-036 SHALL pass this scenario: write_i with line_i=0xDEAD..BEEF pattern; resp_i gapped (1,0,1,1,0,1) -> burst_o shows beats 0..3 in order, each held across gaps; write_o drops after the 4th accept; resp_o one pulse.
REQ-037 SHALL pass this scenario: read_i=write_i=1 in IDLE -> write_o=1, read_o=0, line_o unchanged.
REQ-038 SHALL pass this scenario: rst asserted after 2 read beats -> IDLE next cycle, line_o=0, no resp_o; a fresh read then completes normally.
REQ-039 SHALL pass this scenario: a new read_i pulse and stray resp_i during a write burst -> ignored; only 4 beats sent; resp_o exactly once.
REQ-040 SHALL pass this scenario: two back-to-back reads -> line_o holds the first line until the second burst's beat 0 arrives.
